// File: rtl/crack_pkg.sv
// Shared types and constants for the crack controller slice.
package crack_pkg;

    localparam int unsigned CHARS            = 8;
    localparam int unsigned CHAR_W           = 7;
    localparam int unsigned CAND_W           = CHARS * CHAR_W;
    localparam int unsigned HASH_LAT_DEFAULT = 8;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [CAND_W-1:0] cand_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/crack_controller_if.sv
// Hash-pipeline and match-output signals of the crack controller.
// master = controller side, slave = hash pipeline / match consumer side.
interface crack_controller_if;
    import crack_pkg::*;

    cand_t       hp_chars;
    logic [31:0] hp_seed;
    logic [31:0] hp_hash;
    logic        m_valid;
    logic        m_ready;
    cand_t       m_chars;

    modport master (
        output hp_chars, hp_seed, m_valid, m_chars,
        input  hp_hash, m_ready
    );

    modport slave (
        input  hp_chars, hp_seed, m_valid, m_chars,
        output hp_hash, m_ready
    );

endinterface

// File: rtl/crack_controller_candidate_counter.sv
// Odometer over CHARS digits in [lo, hi]; digit 0 steps fastest.
module candidate_counter
    import crack_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  step_i,
    input  char_t lo_i,
    input  char_t hi_i,
    output cand_t chars_o,
    output logic  last_o
);

    char_t [CHARS-1:0] digit_q;
    char_t [CHARS-1:0] digit_d;
    char_t             lo_q;
    char_t             hi_q;
    logic              carry;

    // Next odometer value and all-hi detection.
    always_comb begin
        digit_d = digit_q;
        carry   = 1'b1;
        last_o  = 1'b1;
        for (int unsigned k = 0; k < CHARS; k++) begin
            if (digit_q[k] != hi_q) begin
                last_o = 1'b0;
            end
            if (carry) begin
                if (digit_q[k] == hi_q) begin
                    digit_d[k] = lo_q;
                end else begin
                    digit_d[k] = digit_q[k] + 1'b1;
                    carry      = 1'b0;
                end
            end
        end
    end

    // Digit and range registers: load captures the range, step advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else if (load_i) begin
            digit_q <= {CHARS{lo_i}};
            lo_q    <= lo_i;
            hi_q    <= hi_i;
        end else if (step_i) begin
            digit_q <= digit_d;
        end
    end

    assign chars_o = digit_q;

endmodule

// File: rtl/crack_controller.sv
// Brute-force search controller: issues candidates to an external hash
// pipeline, matches delayed results against a target and queues hits.
module crack_controller
    import crack_pkg::*;
#(
    parameter int unsigned HASH_LAT    = HASH_LAT_DEFAULT,
    parameter int unsigned MATCH_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_seed,
    input  logic [31:0]        cfg_target,
    input  char_t              cfg_char_lo,
    input  char_t              cfg_char_hi,
    crack_controller_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output cand_t              issued
);

    localparam int unsigned PTR_W  = $clog2(MATCH_DEPTH);
    localparam int unsigned DCNT_W = $clog2(HASH_LAT + 1);

    state_e              state_q;
    logic [31:0]         seed_q;
    logic [31:0]         target_q;
    cand_t               issued_q;
    logic [DCNT_W-1:0]   drain_q;

    logic                start_ok;
    logic                range_ok;
    logic                cnt_load;
    cand_t               cand_chars;
    logic                cand_last;

    logic [HASH_LAT-1:0] vld_line_q;
    cand_t [HASH_LAT-1:0] chr_line_q;
    logic                match;

    cand_t               mem_q [MATCH_DEPTH];
    logic [PTR_W:0]      wr_q;
    logic [PTR_W:0]      rd_q;
    logic [PTR_W:0]      fill;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                overflow_q;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign range_ok = cfg_char_lo <= cfg_char_hi;
    assign cnt_load = start_ok && range_ok;

    candidate_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .step_i  (state_q == RUN),
        .lo_i    (cfg_char_lo),
        .hi_i    (cfg_char_hi),
        .chars_o (cand_chars),
        .last_o  (cand_last)
    );

    // Control FSM. Start is only looked at in IDLE/DONE, so a start that
    // coincides with abort in RUN is ignored and the abort wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            seed_q   <= '0;
            target_q <= '0;
            issued_q <= '0;
            drain_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        seed_q   <= cfg_seed;
                        target_q <= cfg_target;
                        issued_q <= '0;
                        state_q  <= range_ok ? RUN : DONE;
                    end
                end
                RUN: begin
                    issued_q <= issued_q + 1'b1;
                    if (abort || cand_last) begin
                        state_q <= DRAIN;
                        drain_q <= DCNT_W'(HASH_LAT - 1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Delay line aligning each issued candidate with its hash result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_line_q <= '0;
            chr_line_q <= '0;
        end else begin
            vld_line_q[0] <= (state_q == RUN);
            chr_line_q[0] <= cand_chars;
            for (int unsigned i = 1; i < HASH_LAT; i++) begin
                vld_line_q[i] <= vld_line_q[i-1];
                chr_line_q[i] <= chr_line_q[i-1];
            end
        end
    end

    assign match      = vld_line_q[HASH_LAT-1] && (bus.hp_hash == target_q);
    assign fill       = wr_q - rd_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == (PTR_W + 1)'(MATCH_DEPTH));
    assign pop        = !fifo_empty && bus.m_ready;
    assign push       = match && (!fifo_full || pop);

    // Match FIFO; a full FIFO still accepts a push when it is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q[PTR_W-1:0]] <= chr_line_q[HASH_LAT-1];
                wr_q                   <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (match && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.hp_chars = (state_q == RUN) ? cand_chars : '0;
    assign bus.hp_seed  = seed_q;
    assign bus.m_valid  = !fifo_empty;
    assign bus.m_chars  = fifo_empty ? '0 : mem_q[rd_q[PTR_W-1:0]];

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;
    assign issued   = issued_q;

endmodule

// File: tb/tb_crack_controller.sv
// Self-checking bench for crack_controller with a behavioural hash pipeline.
`timescale 1ns/1ps
module tb_crack_controller;
    import crack_pkg::*;

    localparam int LAT   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_seed = '0;
    logic [31:0] cfg_target = '0;
    char_t       cfg_char_lo = '0;
    char_t       cfg_char_hi = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    cand_t       issued;

    int n_checks = 0;
    int n_fail   = 0;

    cand_t exp_cands[$];
    cand_t exp_match[$];
    cand_t cand_q[$];
    cand_t got_q[$];

    crack_controller_if bus();

    crack_controller #(
        .HASH_LAT    (LAT),
        .MATCH_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_seed    (cfg_seed),
        .cfg_target  (cfg_target),
        .cfg_char_lo (cfg_char_lo),
        .cfg_char_hi (cfg_char_hi),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .issued      (issued)
    );

    always #5 clk = ~clk;

    // Additive hash: low four digits are order-insensitive, so chosen targets
    // are hit by a known number of candidates.
    function automatic logic [31:0] mix(input cand_t c, input logic [31:0] seed);
        logic [31:0] h;
        logic [31:0] d;
        h = seed;
        for (int k = 0; k < 8; k++) begin
            d = 32'(c[7*k +: 7]);
            if (k < 4) h = h + d;
            else       h = h + (d << (4 * k));
        end
        return h;
    endfunction

    // External hash pipeline, LAT cycles from hp_chars to hp_hash.
    logic [31:0] pipe [LAT] = '{default: 32'h0};
    always @(posedge clk) begin
        pipe[0] <= mix(bus.hp_chars, bus.hp_seed);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.hp_hash = pipe[LAT-1];

    // Observers: issued candidates and accepted match outputs.
    always @(negedge clk) begin
        if (bus.hp_chars != '0) cand_q.push_back(bus.hp_chars);
        if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_chars);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Odometer reference: expected candidates and matches in issue order.
    task automatic model_run(input char_t lo, input char_t hi, input logic [31:0] seed,
                             input logic [31:0] target, input int limit);
        cand_t c;
        char_t d;
        bit    carry;
        exp_cands.delete();
        exp_match.delete();
        if (lo > hi) return;
        c = {8{lo}};
        for (int n = 0; n < limit; n++) begin
            exp_cands.push_back(c);
            if (mix(c, seed) == target) exp_match.push_back(c);
            if (c == {8{hi}}) break;
            carry = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (carry) begin
                    d = c[7*k +: 7];
                    if (d == hi) c[7*k +: 7] = lo;
                    else begin
                        c[7*k +: 7] = d + 7'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input char_t lo, input char_t hi, input logic [31:0] seed,
                               input logic [31:0] target);
        cfg_char_lo = lo;
        cfg_char_hi = hi;
        cfg_seed    = seed;
        cfg_target  = target;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        if (done === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (issued !== '0) begin n_fail++; $display("FAIL reset_issued: got %0d expected 0", issued); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        n_checks++; if (bus.hp_chars !== '0) begin n_fail++; $display("FAIL reset_hp_chars: got %h expected 0", bus.hp_chars); end
        n_checks++; if (bus.hp_seed !== '0) begin n_fail++; $display("FAIL reset_hp_seed: got %h expected 0", bus.hp_seed); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        cand_t       a8;
        cand_t       g;
        cand_t       e;
        logic [31:0] tgt;
        a8  = {8{7'h61}};
        tgt = mix(a8, 32'd5381);
        model_run(7'h61, 7'h61, 32'd5381, tgt, 16);
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b1;
        pulse_start(7'h61, 7'h61, 32'd5381, tgt);
        n_checks++; if (bus.hp_chars !== a8) begin n_fail++; $display("FAIL single_hp_chars: got %h expected %h", bus.hp_chars, a8); end
        n_checks++; if (bus.hp_seed !== 32'd5381) begin n_fail++; $display("FAIL single_hp_seed: got %0d expected 5381", bus.hp_seed); end
        repeat (LAT) tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_drain_end: done=%b busy=%b expected done=0 busy=1", done, busy); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done_cycle: got %b expected 1 at cycle %0d", done, LAT + 2); end
        n_checks++; if (issued !== 56'd1) begin n_fail++; $display("FAIL single_issued: got %0d expected 1", issued); end
        repeat (3) tick();
        n_checks++; if (cand_q.size() != 1) begin n_fail++; $display("FAIL single_cand_count: got %0d expected 1", cand_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = '0;
            if (exp_match.size() > 0) e = exp_match.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL single_match: got %h expected %h", g, e); end
        end
        n_checks++; if (exp_match.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d matches not seen, expected 0", exp_match.size()); end
    endtask

    task automatic test_full_run();
        cand_t       g;
        cand_t       e;
        logic [31:0] tgt;
        bit          ok;
        bit          bad;
        tgt = mix({{7{7'h30}}, 7'h31}, 32'h1234);
        model_run(7'h30, 7'h31, 32'h1234, tgt, 300);
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b1;
        pulse_start(7'h30, 7'h31, 32'h1234, tgt);
        wait_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_done_timeout: done=%b after 2000 cycles, expected 1", done); end
        n_checks++; if (issued !== 56'd256) begin n_fail++; $display("FAIL full_issued: got %0d expected 256", issued); end
        repeat (DEPTH + 2) tick();
        bad = (cand_q.size() != exp_cands.size());
        for (int i = 0; i < cand_q.size() && !bad; i++) if (cand_q[i] !== exp_cands[i]) bad = 1'b1;
        n_checks++; if (bad) begin n_fail++; $display("FAIL full_cand_seq: got %0d candidates (first %h) expected %0d (first %h)", cand_q.size(), (cand_q.size() > 0) ? cand_q[0] : '0, exp_cands.size(), exp_cands[0]); end
        n_checks++; if (got_q.size() == 0 || got_q[0] !== exp_cands[1]) begin n_fail++; $display("FAIL full_first_match: got %h expected second candidate %h", (got_q.size() > 0) ? got_q[0] : '0, exp_cands[1]); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = '0;
            if (exp_match.size() > 0) e = exp_match.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL full_match: got %h expected %h", g, e); end
        end
        n_checks++; if (exp_match.size() != 0) begin n_fail++; $display("FAIL full_missing: %0d matches not seen, expected 0", exp_match.size()); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        cand_t       g;
        cand_t       e;
        logic [31:0] tgt;
        bit          ok;
        bit          exp_ovf;
        int          exp_kept;
        tgt = mix({{6{7'h30}}, 7'h31, 7'h31}, 32'h0);
        model_run(7'h30, 7'h31, 32'h0, tgt, 300);
        exp_ovf  = (exp_match.size() > DEPTH);
        exp_kept = (exp_match.size() > DEPTH) ? DEPTH : exp_match.size();
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b0;
        pulse_start(7'h30, 7'h31, 32'h0, tgt);
        wait_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_done_timeout: done=%b after 2000 cycles, expected 1", done); end
        n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ovf); end
        n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_m_valid_held: got %b expected 1", bus.m_valid); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_pop: got %0d pops expected 0", got_q.size()); end
        bus.m_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        n_checks++; if (got_q.size() != exp_kept) begin n_fail++; $display("FAIL ovf_kept: got %0d entries expected %0d", got_q.size(), exp_kept); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = '0;
            if (exp_match.size() > 0) e = exp_match.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL ovf_order: got %h expected %h", g, e); end
        end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: m_valid got %b expected 0", bus.m_valid); end
        n_checks++; if (overflow !== exp_ovf || done !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: overflow=%b done=%b expected %b/1", overflow, done, exp_ovf); end
    endtask

    task automatic test_abort();
        bit bad;
        model_run(7'h30, 7'h39, 32'h0BAD, 32'hFFFF_FFFF, 10);
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b1;
        pulse_start(7'h30, 7'h39, 32'h0BAD, 32'hFFFF_FFFF);
        repeat (9) tick();
        abort    = 1'b1;
        start    = 1'b1;
        cfg_seed = 32'hDEAD;
        tick();
        abort    = 1'b0;
        start    = 1'b0;
        n_checks++; if (issued !== 56'd10) begin n_fail++; $display("FAIL abort_issued: got %0d expected 10", issued); end
        n_checks++; if (busy !== 1'b1 || bus.hp_chars !== '0) begin n_fail++; $display("FAIL abort_drain: busy=%b hp_chars=%h expected 1/0", busy, bus.hp_chars); end
        n_checks++; if (bus.hp_seed !== 32'h0BAD) begin n_fail++; $display("FAIL abort_seed: got %h expected 00000bad", bus.hp_seed); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL abort_ovf_cleared: got %b expected 0", overflow); end
        repeat (LAT - 1) tick();
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL abort_drain_len: busy=%b done=%b expected 1/0", busy, done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b expected 1", done); end
        repeat (3) tick();
        bad = (cand_q.size() != exp_cands.size());
        for (int i = 0; i < cand_q.size() && !bad; i++) if (cand_q[i] !== exp_cands[i]) bad = 1'b1;
        n_checks++; if (bad) begin n_fail++; $display("FAIL abort_cands: got %0d candidates expected %0d", cand_q.size(), exp_cands.size()); end
    endtask

    task automatic test_reset_midrun();
        cand_t       g;
        cand_t       e;
        logic [31:0] tgt;
        bit          ok;
        tgt = mix({8{7'h30}}, 32'd7);
        model_run(7'h30, 7'h31, 32'd7, tgt, 14);
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b0;
        pulse_start(7'h30, 7'h31, 32'd7, tgt);
        repeat (14) tick();
        n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rstrun_pre_valid: got %b expected 1", bus.m_valid); end
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstrun_state: busy=%b done=%b expected 0/0", busy, done); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstrun_m_valid: got %b expected 0", bus.m_valid); end
        n_checks++; if (issued !== '0 || bus.hp_chars !== '0) begin n_fail++; $display("FAIL rstrun_clear: issued=%0d hp_chars=%h expected 0/0", issued, bus.hp_chars); end
        rst = 1'b0;
        tick();
        tgt = mix({8{7'h62}}, 32'd99);
        model_run(7'h62, 7'h62, 32'd99, tgt, 4);
        cand_q.delete();
        got_q.delete();
        bus.m_ready = 1'b1;
        pulse_start(7'h62, 7'h62, 32'd99, tgt);
        wait_done(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstrun_restart_timeout: done=%b after 100 cycles, expected 1", done); end
        n_checks++; if (issued !== 56'd1) begin n_fail++; $display("FAIL rstrun_restart_issued: got %0d expected 1", issued); end
        repeat (4) tick();
        n_checks++; if (got_q.size() != exp_match.size()) begin n_fail++; $display("FAIL rstrun_restart_count: got %0d matches expected %0d", got_q.size(), exp_match.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = '0;
            if (exp_match.size() > 0) e = exp_match.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rstrun_restart_match: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_bad_range();
        cand_q.delete();
        pulse_start(7'h41, 7'h40, 32'h55, 32'h0);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_state: done=%b busy=%b expected 1/0", done, busy); end
        n_checks++; if (issued !== '0) begin n_fail++; $display("FAIL bad_issued: got %0d expected 0", issued); end
        n_checks++; if (bus.hp_chars !== '0) begin n_fail++; $display("FAIL bad_hp_chars: got %h expected 0", bus.hp_chars); end
        repeat (5) tick();
        n_checks++; if (cand_q.size() != 0 || done !== 1'b1) begin n_fail++; $display("FAIL bad_no_cands: got %0d candidates done=%b expected 0/1", cand_q.size(), done); end
    endtask

    initial begin
        bus.m_ready = 1'b1;
        test_reset();
        test_single();
        test_full_run();
        test_overflow();
        test_abort();
        test_reset_midrun();
        test_bad_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
